kf_iter_sequencer: RTL

//  Iteration sequencer in front of kalman_core. Deserializes measurement frames from a valid/ready stream into Z_k.

---
 rtl/kf_pkg.sv | 15 +
 rtl/kf_iter_sequencer_if.sv | 14 +
 rtl/kf_meas_loader.sv | 56 +++++
 rtl/kf_iter_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Shared types and constants for the Kalman iteration sequencer.
package kf_pkg;

  localparam int KF_MEASURE_DIM = 6;
  localparam int KF_Z_BEAT_W    = $clog2(KF_MEASURE_DIM);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_FINISH
  } kf_seq_state_t;

endpackage

// File: rtl/kf_iter_sequencer_if.sv
// Valid/ready measurement stream feeding the sequencer; master is the source.
interface kf_iter_sequencer_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0] z_tdata;
  logic                  z_tvalid;
  logic                  z_tlast;
  logic                  z_tready;

  modport master (output z_tdata, output z_tvalid, output z_tlast, input z_tready);
  modport slave  (input z_tdata, input z_tvalid, input z_tlast, output z_tready);

endinterface

// File: rtl/kf_meas_loader.sv
// Deserializes one measurement frame into the Z_k register file and checks
// that tlast lines up with the final beat.
module kf_meas_loader
  import kf_pkg::*;
#(
  parameter int MEASURE_DIM = KF_MEASURE_DIM,
  parameter int DATA_WIDTH  = 64,
  parameter int BEAT_W      = KF_Z_BEAT_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_en,
  input  logic [DATA_WIDTH-1:0]             z_tdata,
  input  logic                              z_tvalid,
  input  logic                              z_tlast,
  output logic                              frame_ok,
  output logic                              frame_bad,
  output logic [MEASURE_DIM*DATA_WIDTH-1:0] z_k
);

  logic [BEAT_W-1:0]                 beat_q, beat_d;
  logic [MEASURE_DIM*DATA_WIDTH-1:0] z_k_q, z_k_d;
  logic                              accept;
  logic                              last_beat;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    accept    = load_en && z_tvalid;
    last_beat = (beat_q == BEAT_W'(MEASURE_DIM - 1));
    frame_ok  = accept && last_beat && z_tlast;
    frame_bad = accept && (last_beat != z_tlast);
    beat_d    = beat_q;
    z_k_d     = z_k_q;
    if (accept) begin
      z_k_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = z_tdata;
      // Either a completed or a rejected frame restarts at element 0.
      beat_d = (last_beat || z_tlast) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // NOTE: the Z_k register file is reset because the core may read it before
  // the first frame arrives; a plain storage array would normally skip reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      z_k_q  <= '0;
    end else begin
      beat_q <= beat_d;
      z_k_q  <= z_k_d;
    end
  end

  assign z_k = z_k_q;

endmodule

// File: rtl/kf_iter_sequencer.sv
// Iteration sequencer in front of kalman_core: loads Z_k, starts the core and
// counts iterations. Define KF_SEQ_TIMEOUT_EN to add the RUN/FINISH watchdog.
module kf_iter_sequencer
  import kf_pkg::*;
#(
  parameter int MEASURE_DIM    = KF_MEASURE_DIM,
  parameter int DATA_WIDTH     = 64,
  parameter int ITER_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              go,
  input  logic [ITER_W-1:0]                 num_iter,
  kf_iter_sequencer_if.slave                z_s,
  output logic                              core_start,
  output logic                              mdi_valid,
  output logic [MEASURE_DIM*DATA_WIDTH-1:0] z_k,
  output logic                              all_z_read,
  input  logic                              iter_done,
  input  logic                              filter_done,
  output logic                              busy,
  output logic [ITER_W-1:0]                 iter_cnt,
  output logic                              seq_done,
  output logic                              frame_err,
  output logic                              timeout
);

  kf_seq_state_t     state_q, state_d;
  logic [ITER_W-1:0] num_iter_q, num_iter_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic              core_start_q, core_start_d;
  logic              mdi_valid_q, mdi_valid_d;
  logic              all_z_read_q, all_z_read_d;
  logic              seq_done_q, seq_done_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_ok, frame_bad;
  logic              load_en;

`ifdef KF_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic [31:0] timeout_cfg_unused;
  assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
`endif

  assign load_en = (state_q == ST_LOAD);

  kf_meas_loader #(
    .MEASURE_DIM (MEASURE_DIM),
    .DATA_WIDTH  (DATA_WIDTH),
    .BEAT_W      ($clog2(MEASURE_DIM))
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .z_tdata   (z_s.z_tdata),
    .z_tvalid  (z_s.z_tvalid),
    .z_tlast   (z_s.z_tlast),
    .frame_ok  (frame_ok),
    .frame_bad (frame_bad),
    .z_k       (z_k)
  );

  always_comb begin
    state_d      = state_q;
    num_iter_d   = num_iter_q;
    iter_cnt_d   = iter_cnt_q;
    all_z_read_d = all_z_read_q;
    core_start_d = 1'b0;
    seq_done_d   = 1'b0;
    frame_err_d  = frame_bad;

    case (state_q)
      ST_IDLE: begin
        if (go && (num_iter != '0)) begin
          num_iter_d = num_iter;
          iter_cnt_d = '0;
          state_d    = ST_LOAD;
        end else if (go) begin
          seq_done_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (frame_ok) begin
          // Only the very first frame of a run needs the core start strobe.
          state_d = (iter_cnt_q == '0) ? ST_START : ST_RUN;
          if (iter_cnt_q == num_iter_q - ITER_W'(1)) all_z_read_d = 1'b1;
        end
      end
      ST_START: begin
        core_start_d = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (iter_done) begin
          if (iter_cnt_q != num_iter_q) iter_cnt_d = iter_cnt_q + ITER_W'(1);
          state_d = (iter_cnt_d == num_iter_q) ? ST_FINISH : ST_LOAD;
        end
      end
      ST_FINISH: begin
        if (filter_done) begin
          seq_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef KF_SEQ_TIMEOUT_EN
    // The watchdog overrides any normal completion in the same cycle.
    timeout_d = 1'b0;
    if ((state_q == ST_RUN || state_q == ST_FINISH) &&
        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_d  = 1'b1;
      seq_done_d = 1'b0;
      state_d    = ST_IDLE;
    end
    to_cnt_d = to_cnt_q;
    if (state_d != state_q)                             to_cnt_d = '0;
    else if (state_q == ST_RUN || state_q == ST_FINISH) to_cnt_d = to_cnt_q + TO_W'(1);
`endif

    if (state_d == ST_IDLE) all_z_read_d = 1'b0;
    mdi_valid_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_iter_q   <= '0;
      iter_cnt_q   <= '0;
      core_start_q <= 1'b0;
      mdi_valid_q  <= 1'b0;
      all_z_read_q <= 1'b0;
      seq_done_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef KF_SEQ_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      num_iter_q   <= num_iter_d;
      iter_cnt_q   <= iter_cnt_d;
      core_start_q <= core_start_d;
      mdi_valid_q  <= mdi_valid_d;
      all_z_read_q <= all_z_read_d;
      seq_done_q   <= seq_done_d;
      frame_err_q  <= frame_err_d;
`ifdef KF_SEQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign z_s.z_tready = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_IDLE);
  assign core_start   = core_start_q;
  assign mdi_valid    = mdi_valid_q;
  assign all_z_read   = all_z_read_q;
  assign iter_cnt     = iter_cnt_q;
  assign seq_done     = seq_done_q;
  assign frame_err    = frame_err_q;
`ifdef KF_SEQ_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule
